// File: rtl/if_fetch_stage.sv
// if_fetch_stage: PC register, instruction-memory request and IF/ID pipeline
// register. Applies the hazard unit's PcStall/NOP verdict and EX redirects,
// including a redirect that arrives while a fetch is still outstanding.
module if_fetch_stage #(
    parameter logic [15:0] NOP_INSTR = 16'h0800,
    parameter logic [4:0]  HALT_OP   = 5'b00000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        PcStall,
    input  logic        NOP,
    input  logic        BrTaken,
    input  logic [15:0] BrTarget,
    input  logic [15:0] ImemData,
    input  logic        ImemReady,
    output logic [15:0] ImemAddr,
    output logic        ImemReq,
    output logic [15:0] IfInstr,
    output logic [15:0] IdInstr,
    output logic [15:0] IdPcInc,
    output logic        IdValid,
    output logic        Halted
);

    typedef enum logic [1:0] {
        FETCH      = 2'd0,
        REDIR_WAIT = 2'd1,
        HALTED     = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] pc_q, pc_d;
    logic [15:0] target_q, target_d;
    logic [15:0] id_instr_q, id_instr_d;
    logic [15:0] id_pcinc_q, id_pcinc_d;
    logic        id_valid_q, id_valid_d;
    logic [15:0] pc_inc;

    // 16-bit modulo increment; 16'hFFFE wraps to 16'h0000
    assign pc_inc = pc_q + 16'd2;

    // Fetch-side outputs; the request is suppressed while reset is held
    always_comb begin
        ImemAddr = pc_q;
        ImemReq  = rst && (state_q != HALTED);
        IfInstr  = ((state_q == FETCH) && ImemReady) ? ImemData : NOP_INSTR;
        Halted   = (state_q == HALTED);
        IdInstr  = id_instr_q;
        IdPcInc  = id_pcinc_q;
        IdValid  = id_valid_q;
    end

    // Next-state logic: every path bubbles IF/ID unless a real instruction is latched
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        target_d   = target_q;
        id_instr_d = NOP_INSTR;
        id_pcinc_d = id_pcinc_q;
        id_valid_d = 1'b0;
        unique case (state_q)
            FETCH: begin
                if (BrTaken && ImemReady) begin
                    pc_d = BrTarget;
                end else if (BrTaken) begin
                    // fetch at the old PC still in flight; remember where to go
                    target_d = BrTarget;
                    state_d  = REDIR_WAIT;
                end else if (!ImemReady || PcStall) begin
                    pc_d = pc_q;
                end else if (NOP) begin
                    // squash the delay slot but keep fetching forward
                    pc_d = pc_inc;
                end else begin
                    id_instr_d = ImemData;
                    id_pcinc_d = pc_inc;
                    id_valid_d = 1'b1;
                    if (ImemData[15:11] == HALT_OP) begin
                        state_d = HALTED;
                    end else begin
                        pc_d = pc_inc;
                    end
                end
            end
            REDIR_WAIT: begin
                if (BrTaken) begin
                    target_d = BrTarget;
                end
                // the returning data belongs to the old path and is dropped
                if (ImemReady) begin
                    pc_d    = BrTaken ? BrTarget : target_q;
                    state_d = FETCH;
                end
            end
            HALTED: begin
                // a taken branch older than the halt means the halt was speculative
                if (BrTaken) begin
                    pc_d    = BrTarget;
                    state_d = FETCH;
                end
            end
            default: begin
                state_d = FETCH;
            end
        endcase
    end

    // State, PC and IF/ID registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= FETCH;
            pc_q       <= 16'h0000;
            target_q   <= 16'h0000;
            id_instr_q <= NOP_INSTR;
            id_pcinc_q <= 16'h0000;
            id_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            target_q   <= target_d;
            id_instr_q <= id_instr_d;
            id_pcinc_q <= id_pcinc_d;
            id_valid_q <= id_valid_d;
        end
    end

endmodule

// File: tb/tb_if_fetch_stage.sv
// tb_if_fetch_stage: directed scenarios with literal expectations, then random
// stimulus, all compared every cycle against a behavioural fetch model.
module tb_if_fetch_stage;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        PcStall = 1'b0;
    logic        NOP = 1'b0;
    logic        BrTaken = 1'b0;
    logic [15:0] BrTarget = 16'h0000;
    logic [15:0] ImemData = 16'h0000;
    logic        ImemReady = 1'b0;
    logic [15:0] ImemAddr;
    logic        ImemReq;
    logic [15:0] IfInstr;
    logic [15:0] IdInstr;
    logic [15:0] IdPcInc;
    logic        IdValid;
    logic        Halted;

    if_fetch_stage dut (
        .clk       (clk),
        .rst       (rst),
        .PcStall   (PcStall),
        .NOP       (NOP),
        .BrTaken   (BrTaken),
        .BrTarget  (BrTarget),
        .ImemData  (ImemData),
        .ImemReady (ImemReady),
        .ImemAddr  (ImemAddr),
        .ImemReq   (ImemReq),
        .IfInstr   (IfInstr),
        .IdInstr   (IdInstr),
        .IdPcInc   (IdPcInc),
        .IdValid   (IdValid),
        .Halted    (Halted)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc_no = 0;

    // behavioural model: mode 0 = running, 1 = waiting out a stale fetch, 2 = halted
    int          m_mode;
    logic [15:0] m_pc, m_tgt, m_id_instr, m_id_pcinc;
    logic        m_id_valid;
    logic        m_in_reset;
    logic [15:0] mem [256];

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s cycle=%0d actual=%h required=%h", nm, cyc_no, act, exp);
        end
    endtask

    task automatic model_reset();
        m_mode = 0; m_pc = 16'h0000; m_tgt = 16'h0000;
        m_id_instr = 16'h0800; m_id_pcinc = 16'h0000; m_id_valid = 1'b0;
    endtask

    // every-cycle comparison of all outputs against the model
    task automatic cmp_all();
        chk("ImemAddr", ImemAddr, m_pc);
        chk("ImemReq", {15'd0, ImemReq}, {15'd0, !m_in_reset && m_mode != 2});
        chk("IfInstr", IfInstr, (m_mode == 0 && ImemReady) ? ImemData : 16'h0800);
        chk("IdInstr", IdInstr, m_id_instr);
        chk("IdPcInc", IdPcInc, m_id_pcinc);
        chk("IdValid", {15'd0, IdValid}, {15'd0, m_id_valid});
        chk("Halted", {15'd0, Halted}, {15'd0, m_mode == 2});
    endtask

    task automatic model_step(input logic st, input logic nop, input logic br,
                              input logic [15:0] bt, input logic rdy, input logic [15:0] dat);
        logic [15:0] nxt;
        logic        take;
        nxt  = m_pc + 16'd2;
        take = 1'b0;
        if (m_mode == 0) begin
            if (br && rdy) m_pc = bt;
            else if (br) begin m_tgt = bt; m_mode = 1; end
            else if (!rdy || st) ;
            else if (nop) m_pc = nxt;
            else begin
                take = 1'b1;
                if (dat[15:11] == 5'b00000) m_mode = 2;
                else m_pc = nxt;
            end
        end else if (m_mode == 1) begin
            if (br) m_tgt = bt;
            if (rdy) begin m_pc = m_tgt; m_mode = 0; end
        end else begin
            if (br) begin m_pc = bt; m_mode = 0; end
        end
        if (take) begin
            m_id_instr = dat; m_id_pcinc = nxt; m_id_valid = 1'b1;
        end else begin
            m_id_instr = 16'h0800; m_id_valid = 1'b0;
        end
    endtask

    // one clock: drive, compare, advance model, wait for the edge
    task automatic cyc(input logic st, input logic nop, input logic br,
                       input logic [15:0] bt, input logic rdy, input logic [15:0] dat);
        PcStall = st; NOP = nop; BrTaken = br; BrTarget = bt; ImemReady = rdy; ImemData = dat;
        #1;
        cmp_all();
        $display("cyc %0d pc=%h st=%0b nop=%0b br=%0b bt=%h rdy=%0b dat=%h id=%h inc=%h v=%0b h=%0b",
                 cyc_no, ImemAddr, st, nop, br, bt, rdy, dat, IdInstr, IdPcInc, IdValid, Halted);
        model_step(st, nop, br, bt, rdy, dat);
        @(posedge clk); #1;
        cyc_no++;
    endtask

    // asynchronous reset asserted away from the clock edge
    task automatic do_reset();
        #2 rst = 1'b0;
        PcStall = 0; NOP = 0; BrTaken = 0; BrTarget = 0; ImemReady = 0; ImemData = 0;
        m_in_reset = 1'b1;
        model_reset();
        #1;
        chk("rst_ImemReq", {15'd0, ImemReq}, 16'd0);
        chk("rst_IdInstr", IdInstr, 16'h0800);
        chk("rst_IdPcInc", IdPcInc, 16'h0000);
        chk("rst_IdValid", {15'd0, IdValid}, 16'd0);
        chk("rst_Halted", {15'd0, Halted}, 16'd0);
        chk("rst_ImemAddr", ImemAddr, 16'h0000);
        @(posedge clk); #1;
        rst = 1'b1;
        m_in_reset = 1'b0;
        #1;
        chk("post_rst_ImemReq", {15'd0, ImemReq}, 16'd1);
        chk("post_rst_ImemAddr", ImemAddr, 16'h0000);
    endtask

    initial begin
        logic [15:0] w;
        m_in_reset = 1'b1;
        model_reset();
        for (int i = 0; i < 256; i++) mem[i] = 16'($urandom);
        @(posedge clk); #1;

        // straight-line program ending in a halt
        do_reset();
        cyc(0, 0, 0, 16'h0, 1, 16'h4001);
        chk("t1_id0", IdInstr, 16'h4001); chk("t1_inc0", IdPcInc, 16'h0002);
        cyc(0, 0, 0, 16'h0, 1, 16'h4002);
        chk("t1_id1", IdInstr, 16'h4002); chk("t1_inc1", IdPcInc, 16'h0004);
        cyc(0, 0, 0, 16'h0, 1, 16'h4003);
        chk("t1_id2", IdInstr, 16'h4003); chk("t1_inc2", IdPcInc, 16'h0006);
        cyc(0, 0, 0, 16'h0, 1, 16'h0000);
        chk("t1_id3", IdInstr, 16'h0000); chk("t1_inc3", IdPcInc, 16'h0008);
        chk("t1_halted", {15'd0, Halted}, 16'd1);
        chk("t1_req", {15'd0, ImemReq}, 16'd0);
        chk("t1_pc", ImemAddr, 16'h0006);
        cyc(0, 0, 0, 16'h0, 1, 16'h4001);
        chk("t1_pc_hold", ImemAddr, 16'h0006);
        chk("t1_bubble", {15'd0, IdValid}, 16'd0);
        // speculative halt released by a taken branch
        cyc(0, 0, 1, 16'h0020, 1, 16'h4001);
        chk("halt_exit_h", {15'd0, Halted}, 16'd0);
        chk("halt_exit_pc", ImemAddr, 16'h0020);
        chk("halt_exit_req", {15'd0, ImemReq}, 16'd1);

        // stall, then NOP squash
        do_reset();
        cyc(0, 0, 0, 16'h0, 1, 16'h4001);
        cyc(0, 0, 0, 16'h0, 1, 16'h4002);
        for (int i = 0; i < 2; i++) begin
            cyc(1, 1, 0, 16'h0, 1, 16'h4003);
            chk("stall_pc", ImemAddr, 16'h0004);
            chk("stall_bubble", {15'd0, IdValid}, 16'd0);
        end
        cyc(0, 0, 0, 16'h0, 1, 16'h4003);
        chk("stall_resume", ImemAddr, 16'h0006);
        chk("stall_resume_id", IdInstr, 16'h4003);
        cyc(0, 0, 0, 16'h0, 1, 16'h4004);
        cyc(0, 1, 0, 16'h0, 1, 16'h4005);
        chk("nop_pc", ImemAddr, 16'h000A);
        chk("nop_id", IdInstr, 16'h0800);

        // redirect while the fetch is outstanding
        cyc(0, 0, 1, 16'h0100, 0, 16'h1111);
        chk("redir_req", {15'd0, ImemReq}, 16'd1);
        chk("redir_pc_old", ImemAddr, 16'h000A);
        cyc(0, 0, 0, 16'h0, 0, 16'h2222);
        cyc(0, 0, 0, 16'h0, 0, 16'h3333);
        cyc(0, 0, 0, 16'h0, 1, 16'h4777);
        chk("redir_pc", ImemAddr, 16'h0100);
        chk("redir_drop", {15'd0, IdValid}, 16'd0);
        cyc(0, 0, 0, 16'h0, 1, 16'h4008);
        chk("redir_id", IdInstr, 16'h4008); chk("redir_inc", IdPcInc, 16'h0102);

        // odd target kept as-is, then PC wrap
        cyc(0, 0, 1, 16'h0101, 1, 16'h4009);
        chk("odd_tgt", ImemAddr, 16'h0101);
        cyc(0, 0, 1, 16'hFFFE, 1, 16'h4009);
        chk("wrap_pc0", ImemAddr, 16'hFFFE);
        cyc(0, 0, 0, 16'h0, 1, 16'h400A);
        chk("wrap_pc", ImemAddr, 16'h0000);
        chk("wrap_inc", IdPcInc, 16'h0000);
        chk("wrap_id", IdInstr, 16'h400A);

        // reset during a redirect wait forgets the target
        cyc(0, 0, 1, 16'h0300, 0, 16'h5555);
        do_reset();
        cyc(0, 0, 0, 16'h0, 1, 16'h400B);
        chk("midwait_pc", ImemAddr, 16'h0002);
        chk("midwait_id", IdInstr, 16'h400B);

        // random traffic against the model
        for (int i = 0; i < 1500; i++) begin
            logic rdy, br;
            rdy = ($urandom_range(0, 3) != 0);
            br  = ($urandom_range(0, 9) == 0);
            w   = rdy ? mem[m_pc[8:1]] : 16'($urandom);
            cyc($urandom_range(0, 5) == 0, $urandom_range(0, 5) == 0, br,
                16'($urandom), rdy, w);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
